// File: rtl/ghost_pkg.sv
// Shared ghost sprite definitions: detector FSM states, HitEdgeCode bit layout
// and default sprite size, common to the mover and the collision detector.
package ghost_pkg;

  typedef enum logic [1:0] {
    IDLE_ST,
    SCAN_ST,
    DELAY_ST,
    REPORT_ST
  } ghost_state_t;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  localparam int DEF_OBJECT_WIDTH_X = 64;
  localparam int DEF_OBJECT_HIGHT_Y = 64;

  localparam int HIT_CNT_W = 12;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] value,
                                                   input logic                 en);
    return (en && (value != '1)) ? value + HIT_CNT_W'(1) : value;
  endfunction

endpackage

// File: rtl/ghost_edge_classify.sv
// Maps a pixel offset inside the ghost box to the set of ghost edges it lies on.
// Corner pixels set two bits; interior pixels set none.
module ghost_edge_classify
  import ghost_pkg::*;
#(
  parameter int OBJECT_WIDTH_X = DEF_OBJECT_WIDTH_X,
  parameter int OBJECT_HIGHT_Y = DEF_OBJECT_HIGHT_Y,
  parameter int EDGE_MARGIN    = 8
) (
  input  logic signed [11:0] offX,
  input  logic signed [11:0] offY,
  output logic        [3:0]  edge_mask
);

  localparam logic signed [11:0] MARGIN_S = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] RIGHT_S  = 12'(OBJECT_WIDTH_X - EDGE_MARGIN);
  localparam logic signed [11:0] BOTTOM_S = 12'(OBJECT_HIGHT_Y - EDGE_MARGIN);

  always_comb begin
    // NOTE: default every output first so no path through the block infers a latch.
    edge_mask              = '0;
    edge_mask[EDGE_LEFT]   = (offX <  MARGIN_S);
    edge_mask[EDGE_RIGHT]  = (offX >= RIGHT_S);
    edge_mask[EDGE_TOP]    = (offY <  MARGIN_S);
    edge_mask[EDGE_BOTTOM] = (offY >= BOTTOM_S);
  end

endmodule

// File: rtl/ghost_collision_detect.sv
// Per-frame ghost/wall overlap detector: accumulates edge hits and overlap count
// over a frame, then emits one delayed collision pulse with a stable edge code.
module ghost_collision_detect
  import ghost_pkg::*;
#(
  parameter int OBJECT_WIDTH_X = DEF_OBJECT_WIDTH_X,
  parameter int OBJECT_HIGHT_Y = DEF_OBJECT_HIGHT_Y,
  parameter int EDGE_MARGIN    = 8,
  parameter int MIN_HIT_PIXELS = 4,
  parameter int REPORT_DELAY   = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic signed [10:0]   topLeftX,
  input  logic signed [10:0]   topLeftY,
  input  logic                 ghostDR,
  input  logic                 wallDR,
  output logic                 collision,
  output logic [3:0]           HitEdgeCode,
  output logic [HIT_CNT_W-1:0] hitPixels
);

  localparam int                DLY_W    = (REPORT_DELAY > 1) ? $clog2(REPORT_DELAY) : 1;
  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(REPORT_DELAY - 1);
  localparam logic [HIT_CNT_W-1:0] MIN_HITS = HIT_CNT_W'(MIN_HIT_PIXELS);

  ghost_state_t          state;
  logic [DLY_W-1:0]      dly_cnt;
  logic [3:0]            acc_edge, rep_edge;
  logic [HIT_CNT_W-1:0]  acc_cnt, rep_cnt;

  logic                  overlap;
  logic signed [11:0]    off_x, off_y;
  logic [3:0]            pix_mask, hit_mask;
  logic [HIT_CNT_W-1:0]  first_cnt;

  assign overlap   = ghostDR & wallDR;
  assign off_x     = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y     = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});
  assign hit_mask  = overlap ? pix_mask : 4'b0000;
  // An overlap on the startOfFrame cycle seeds the new frame's accumulators.
  assign first_cnt = HIT_CNT_W'(overlap);

  ghost_edge_classify #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HIGHT_Y (OBJECT_HIGHT_Y),
    .EDGE_MARGIN    (EDGE_MARGIN)
  ) u_classify (
    .offX      (off_x),
    .offY      (off_y),
    .edge_mask (pix_mask)
  );

  // NOTE: sequential state uses non-blocking assignments; later assignments in
  // the same clock override the default accumulate/clear below.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE_ST;
      dly_cnt     <= '0;
      acc_edge    <= '0;
      acc_cnt     <= '0;
      rep_edge    <= '0;
      rep_cnt     <= '0;
      collision   <= 1'b0;
      HitEdgeCode <= '0;
      hitPixels   <= '0;
    end else begin
      collision <= 1'b0;
      if (state != IDLE_ST) begin
        acc_edge <= acc_edge | hit_mask;
        acc_cnt  <= sat_inc(acc_cnt, overlap);
      end

      case (state)
        IDLE_ST: begin
          if (startOfFrame) begin
            acc_edge <= hit_mask;
            acc_cnt  <= first_cnt;
            state    <= SCAN_ST;
          end
        end
        default: begin
          // A new frame always wins, even over a report still in flight.
          if (startOfFrame) begin
            rep_edge <= acc_edge;
            rep_cnt  <= acc_cnt;
            acc_edge <= hit_mask;
            acc_cnt  <= first_cnt;
            dly_cnt  <= '0;
            state    <= DELAY_ST;
          end else if (state == DELAY_ST) begin
            dly_cnt <= dly_cnt + DLY_W'(1);
            if (dly_cnt == DLY_LAST) state <= REPORT_ST;
          end else if (state == REPORT_ST) begin
            hitPixels <= rep_cnt;
            if (rep_cnt >= MIN_HITS) begin
              collision   <= 1'b1;
              HitEdgeCode <= rep_edge;
            end
            state <= SCAN_ST;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_collision_detect.sv
// Scoreboard bench for ghost_collision_detect: a frame-level pixel model predicts
// each report; a negedge monitor checks every output on every cycle.
`timescale 1ns/1ps
module tb_ghost_collision_detect;

  localparam int W_X   = 64;
  localparam int H_Y   = 64;
  localparam int MARG  = 8;
  localparam int MINH  = 4;
  localparam int RDLY  = 4;

  logic               clk = 1'b0;
  logic               resetN, startOfFrame, ghostDR, wallDR;
  logic [10:0]        pixelX, pixelY;
  logic signed [10:0] topLeftX, topLeftY;
  logic               collision;
  logic [3:0]         HitEdgeCode;
  logic [11:0]        hitPixels;

  ghost_collision_detect #(
    .OBJECT_WIDTH_X (W_X),
    .OBJECT_HIGHT_Y (H_Y),
    .EDGE_MARGIN    (MARG),
    .MIN_HIT_PIXELS (MINH),
    .REPORT_DELAY   (RDLY)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .ghostDR      (ghostDR),
    .wallDR       (wallDR),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .hitPixels    (hitPixels)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       target;
    bit       coll;
    logic [3:0] edg;
    int       cnt;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  bit         mon_en = 1'b0;
  logic [3:0] hold_edge = 4'b0000;
  int         hold_cnt  = 0;

  // Reference model: the overlap pixels of the frame currently being scanned.
  bit active = 1'b0;
  int frame_ox[$];
  int frame_oy[$];
  int tl_x = 100;
  int tl_y = 100;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] ref_edges(input int ox, input int oy);
    logic [3:0] m;
    m[3] = (ox < MARG);
    m[2] = (oy < MARG);
    m[1] = (ox >= W_X - MARG);
    m[0] = (oy >= H_Y - MARG);
    return m;
  endfunction

  // Called on a startOfFrame that closes a scanned frame.
  task automatic frame_report();
    exp_t e;
    e.edg = 4'b0000;
    for (int i = 0; i < frame_ox.size(); i++) e.edg |= ref_edges(frame_ox[i], frame_oy[i]);
    e.cnt    = (frame_ox.size() > 4095) ? 4095 : frame_ox.size();
    e.coll   = (e.cnt >= MINH);
    e.target = cyc + 1 + RDLY + 1;
    sb.push_back(e);
  endtask

  task automatic step(input bit sof, input bit g, input bit w, input int ox, input int oy);
    startOfFrame = sof;
    ghostDR      = g;
    wallDR       = w;
    pixelX       = 11'(tl_x + ox);
    pixelY       = 11'(tl_y + oy);
    topLeftX     = 11'(tl_x);
    topLeftY     = 11'(tl_y);
    if (sof) begin
      // A report still pending at this startOfFrame never happens.
      while (sb.size() > 0 && sb[$].target >= cyc + 1) void'(sb.pop_back());
      if (active) frame_report();
      active = 1'b1;
      frame_ox.delete();
      frame_oy.delete();
    end
    if (active && g && w) begin
      frame_ox.push_back(ox);
      frame_oy.push_back(oy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    ghostDR      = 1'b1;
    wallDR       = 1'b1;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    sb.delete();
    active = 1'b0;
    frame_ox.delete();
    frame_oy.delete();
    hold_edge = 4'b0000;
    hold_cnt  = 0;
  endtask

  // startOfFrame cycle (ghost only), then n_hits overlaps at one offset, then filler.
  task automatic run_frame(input int len, input int n_hits, input int ox, input int oy);
    step(1'b1, 1'b1, 1'b0, ox, oy);
    for (int i = 1; i < len; i++) begin
      if (i <= n_hits) step(1'b0, 1'b1, 1'b1, ox, oy);
      else             step(1'b0, i[0], ~i[0], ox, oy);
    end
  endtask

  task automatic random_frame(input int len);
    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 83)) - 10, int'($urandom_range(0, 83)) - 10);
    for (int i = 1; i < len; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 83)) - 10, int'($urandom_range(0, 83)) - 10);
  endtask

  exp_t mon_e;
  bit   mon_c;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_c = 1'b0;
      if (sb.size() > 0 && sb[0].target == cyc) begin
        mon_e    = sb.pop_front();
        mon_c    = mon_e.coll;
        hold_cnt = mon_e.cnt;
        if (mon_e.coll) hold_edge = mon_e.edg;
      end
      check("collision", int'(collision), int'(mon_c));
      check("HitEdgeCode", int'(HitEdgeCode), int'(hold_edge));
      check("hitPixels", int'(hitPixels), hold_cnt);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; ghostDR = 1'b0; wallDR = 1'b0;
    pixelX = '0; pixelY = '0; topLeftX = '0; topLeftY = '0;
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    mon_en = 1'b1;

    // Empty frame, then the left-edge, sub-threshold and corner frames.
    run_frame(20, 0, 30, 30);
    run_frame(20, 10, 2, 30);
    run_frame(20, 3, 30, 60);
    run_frame(20, 6, 62, 1);
    // Overlap on the startOfFrame cycle belongs to the next frame.
    step(1'b1, 1'b1, 1'b1, 30, 30);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 1'b1, 30, 62);
    // Second startOfFrame two clocks later abandons the first report.
    run_frame(2, 1, 4, 4);
    run_frame(20, 5, 40, 3);
    // Reset while the report is delayed.
    step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 30, 62);
    step(1'b0, 1'b1, 1'b1, 30, 62);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1, 1);
    run_frame(20, 8, 63, 63);
    run_frame(20, 4, 7, 56);
    // Ghost partly off-screen to the left.
    tl_x = -5;
    tl_y = 200;
    run_frame(20, 6, 7, 20);
    run_frame(20, 0, 0, 0);

    for (int f = 0; f < 40; f++) begin
      tl_x = int'($urandom_range(20, 1000));
      tl_y = int'($urandom_range(20, 1000));
      random_frame(int'($urandom_range(2, 40)));
    end

    // Long frame drives the counter into saturation.
    tl_x = 500;
    tl_y = 500;
    run_frame(4110, 4100, 20, 20);
    run_frame(20, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 0, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
